kgp_fetch_unit: RTL and testbench

Instruction fetch stage of the KGP-RISC core. It owns the program counter and issues word reads to the instruction memory, which has a fixed 1-cycle read latency. Returned words are buffered in a small FIFO and handed to decode with a valid/ready handshake. Branch/jump redirects from execute flush the buffer and restart fetch at a new PC.

---
 rtl/kgp_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_kgp_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/kgp_fetch_unit.sv
// KGP-RISC instruction fetch: PC, 1-cycle imem reads, small decode buffer, redirect flush.
// Optional perf counters (perf_fetched/perf_flushed) when FETCH_PERF_CNT_EN is defined.
module kgp_fetch_unit #(
  parameter int               ADDR_W     = 32,
  parameter int               DATA_W     = 32,
  parameter int               FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int               PC_STEP    = 4,
  localparam int              PTR_W      = $clog2(FIFO_DEPTH),
  localparam int              CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [DATA_W-1:0] dec_instr,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [CNT_W-1:0]  fifo_count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   ret_pc_q;
  logic                inflight_q, drop_q;
  logic [DATA_W-1:0]   buf_instr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]   buf_pc_q    [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W:0]      occ;
  logic                issue, push, pop;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (halt) state_d = HALTED;
      HALTED:  if (!halt) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign dec_valid  = (count_q != '0);
  assign pop        = dec_valid & dec_ready;
  // A pop this cycle frees a slot in time for the word issued now, keeping 1 instr/cycle.
  assign occ        = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
  assign issue      = (state_q == RUN) && !halt && !redirect_valid &&
                      (occ < (CNT_W+1)'(FIFO_DEPTH));
  assign push       = inflight_q && !drop_q && !redirect_valid;

  assign imem_req   = issue;
  assign imem_addr  = pc_q;
  assign fifo_count = count_q;
  assign dec_instr  = dec_valid ? buf_instr_q[rd_ptr_q] : '0;
  assign dec_pc     = dec_valid ? buf_pc_q[rd_ptr_q]    : '0;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)
      pc_d = redirect_pc;
    else if (issue)
      pc_d = pc_q + ADDR_W'(PC_STEP);
  end

  always_comb begin
    count_d = count_q;
    if (redirect_valid)
      count_d = '0;
    else
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= issue;
      drop_q     <= redirect_valid & inflight_q;
      count_q    <= count_d;
      if (redirect_valid) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Buffer storage and return address carry no reset; occupancy gates their use.
  always_ff @(posedge clk) begin
    if (issue) ret_pc_q <= pc_q;
    if (push) begin
      buf_instr_q[wr_ptr_q] <= imem_rdata;
      buf_pc_q[wr_ptr_q]    <= ret_pc_q;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  logic [31:0] fetched_q, flushed_q, flush_amt;

  // Words lost to a redirect: buffered entries not taken by decode plus the returning word.
  assign flush_amt    = 32'(count_q) - 32'(pop) + 32'(inflight_q);
  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= sat_add(fetched_q, 32'(push));
      if (redirect_valid) flushed_q <= sat_add(flushed_q, flush_amt);
    end
  end
`endif

endmodule

// File: tb/tb_kgp_fetch_unit.sv
// Bench for kgp_fetch_unit: program-order scoreboard plus directed latency/stall/redirect/halt/reset steps.
module tb_kgp_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_instr, dec_pc;
  logic [1:0]  fifo_count;

  logic        w_req, w_dec_valid;
  logic [31:0] w_addr, w_rdata, w_dec_instr, w_dec_pc;
  logic [1:0]  w_fifo_count;
  logic        w_one  = 1'b1;
  logic        w_zero = 1'b0;
  logic [31:0] w_zpc  = 32'h0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed, w_perf_fetched, w_perf_flushed;
`endif

  kgp_fetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(2), .RESET_PC(32'h0), .PC_STEP(4)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .fifo_count(fifo_count)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  kgp_fetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(2), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .redirect_valid(w_zero), .redirect_pc(w_zpc), .halt(w_zero),
    .dec_valid(w_dec_valid), .dec_ready(w_one), .dec_instr(w_dec_instr), .dec_pc(w_dec_pc),
    .fifo_count(w_fifo_count)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(w_perf_fetched), .perf_flushed(w_perf_flushed)
`endif
  );

  // Instruction memory content is a fixed function of the address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  // 1-cycle latency memories; garbage when no request was made.
  always @(posedge clk) imem_rdata <= imem_req ? word_of(imem_addr) : $urandom();
  always @(posedge clk) w_rdata    <= w_req    ? word_of(w_addr)    : $urandom();

  int          total = 0;
  int          bad   = 0;
  int          acc   = 0;
  logic [31:0] exp_pc, w_exp, prev_pc, saved_pc;
  bit          prev_hold, prev_redir, seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock with scoreboard checks; inputs were set at the preceding negedge.
  task automatic cyc();
    #1;
    if (prev_hold) begin
      chk("hold_valid", 32'(dec_valid), 32'd1);
      chk("hold_pc", dec_pc, prev_pc);
    end
    if (prev_redir) chk("post_redirect_valid", 32'(dec_valid), 32'd0);
    if (halt || redirect_valid || (fifo_count == 2'd2 && !dec_ready))
      chk("no_req", 32'(imem_req), 32'd0);
    chk("count_le_depth", 32'(fifo_count > 2'd2), 32'd0);
    if (dec_valid && dec_ready) begin
      chk("dec_pc", dec_pc, exp_pc);
      chk("dec_instr", dec_instr, word_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
      acc++;
    end
    if (redirect_valid) exp_pc = redirect_pc;
    prev_hold  = dec_valid && !dec_ready && !redirect_valid;
    prev_pc    = dec_pc;
    prev_redir = redirect_valid;
    if (w_dec_valid) begin
      chk("wrap_pc", w_dec_pc, w_exp);
      w_exp = w_exp + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Release reset with decode ready and check first-valid latency and back-to-back flow.
  task automatic release_and_run();
    exp_pc     = 32'h0;
    w_exp      = 32'hFFFF_FFF8;
    prev_hold  = 1'b0;
    prev_redir = 1'b0;
    dec_ready  = 1'b1;
    rst        = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("valid_latency", 32'(dec_valid), 32'(i >= 3));
      cyc();
    end
  endtask

  initial begin
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    dec_ready      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(dec_valid), 32'd0);
    chk("rst_instr", dec_instr, 32'h0);
    chk("rst_pc", dec_pc, 32'h0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
    @(negedge clk);

    release_and_run();

    // Decode stall: buffer fills, requests stop, head stays put.
    dec_ready = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    #1;
    chk("stall_count", 32'(fifo_count), 32'd2);
    chk("stall_req", 32'(imem_req), 32'd0);
    dec_ready = 1'b1;
    for (int i = 0; i < 6; i++) cyc();

    // Redirect with a loaded buffer and a word in flight.
    dec_ready = 1'b0;
    cyc();
    dec_ready = 1'b1;
    cyc();
    dec_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cyc();
    redirect_valid = 1'b0;
    dec_ready      = 1'b1;
    saved_pc       = acc;
    for (int i = 0; i < 6; i++) cyc();
    chk("redirect_progress", 32'(acc - int'(saved_pc) >= 3), 32'd1);

    // Halt: no requests, buffer drains, fetch resumes where it stopped.
    halt = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
    #1;
    chk("halt_drained_valid", 32'(dec_valid), 32'd0);
    chk("halt_drained_count", 32'(fifo_count), 32'd0);
    saved_pc = exp_pc;
    halt     = 1'b0;
    seen     = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (imem_req && !seen) begin
        chk("resume_addr", imem_addr, saved_pc);
        seen = 1'b1;
      end
      cyc();
    end
    chk("resume_seen", 32'(seen), 32'd1);

    // Randomized traffic against the program-order scoreboard.
    acc = 0;
    for (int i = 0; i < 600; i++) begin
      dec_ready      = ($urandom_range(0, 9) < 7);
      halt           = ($urandom_range(0, 9) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom() & 32'hFFFF_FFFC;
      cyc();
    end
    halt           = 1'b0;
    redirect_valid = 1'b0;
    dec_ready      = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    chk("random_progress", 32'(acc > 150), 32'd1);

    // Asynchronous reset while the buffer is full.
    dec_ready = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    #1;
    chk("full_before_reset", 32'(fifo_count), 32'd2);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(dec_valid), 32'd0);
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_count", 32'(fifo_count), 32'd0);
    chk("arst_addr", imem_addr, 32'h0);
    @(negedge clk);
    release_and_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
